// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared FSM encoding and trace entry layout for trace_capture
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int INSTR_W = 32;
  localparam int RD_AW   = 5;

  // Packed entry, MSB first: {rd_we, rd_addr, rd_data, instr, pc, cycle}
  function automatic int entry_w(input int xlen, input int cw);
    return 1 + RD_AW + xlen + INSTR_W + xlen + cw;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - trace entry buffer with head/tail/count; TRACE_WRAP_EN selects
// overwrite-oldest instead of drop when a write hits a full buffer
module trace_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [W-1:0]    wr_data,
  input  logic            rd_en,
  output logic [W-1:0]    rd_data,
  output logic [CNTW-1:0] count,
  output logic            overflow
);

`ifdef TRACE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic          full, empty, do_rd, wr_store, head_adv, lost;

  assign full     = (count == CNTW'(DEPTH));
  assign empty    = (count == '0);
  assign do_rd    = rd_en && !empty;
  assign wr_store = wr_en && !clr && (!full || do_rd || WRAP);
  // Overwriting the oldest entry retires it, so head moves exactly like a read.
  assign head_adv = do_rd || (wr_en && full && WRAP);
  assign lost     = wr_en && full && !do_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_store) tail <= tail + AW'(1);
      if (head_adv) head <= head + AW'(1);
      count <= count + CNTW'(wr_store) - CNTW'(head_adv);
      if (lost) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_store) mem[tail] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[head];

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - commit tracer: capture window FSM, cycle stamping, x0 filtering;
// buffer full policy selected by TRACE_WRAP_EN
module trace_capture
  import trace_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int DEPTH      = 32,
  parameter  int MAX_CYCLES = 30,
  localparam int CW         = $clog2(MAX_CYCLES + 1),
  localparam int CNTW       = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            rd_we_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     out_instr_o,
  output logic            out_rd_we_o,
  output logic [4:0]      out_rd_addr_o,
  output logic [XLEN-1:0] out_rd_data_o,
  output logic [CW-1:0]   out_cycle_o,
  output logic [CNTW-1:0] count_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            overflow_o
);

  localparam int          EW   = entry_w(XLEN, CW);
  localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);

  state_t         state;
  logic [CW-1:0]  cyc;
  logic           fifo_clr, wr_en;
  logic [EW-1:0]  wr_data, rd_data;

  assign fifo_clr = start_i && (state == ST_IDLE || state == ST_DONE);
  assign wr_en    = (state == ST_CAPTURE) && commit_valid_i;
  // Writes to x0 have no architectural effect, so they are never reported as writes.
  assign wr_data  = {rd_we_i && (rd_addr_i != 5'd0), rd_addr_i, rd_data_i, instr_i, pc_i, cyc};

  trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (fifo_clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (out_ready_i),
    .rd_data  (rd_data),
    .count    (count_o),
    .overflow (overflow_o)
  );

  assign {out_rd_we_o, out_rd_addr_o, out_rd_data_o, out_instr_o, out_pc_o, out_cycle_o} = rd_data;
  assign out_valid_o = (count_o != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      cyc    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cyc <= '0;
          if (start_i) begin
            state  <= ST_CAPTURE;
            busy_o <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          cyc <= cyc + CW'(1);
          if (cyc == LAST) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (count_o == '0) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start_i) begin
            state  <= ST_CAPTURE;
            cyc    <= '0;
            busy_o <= 1'b1;
            done_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - directed table-driven bench for trace_capture (DEPTH=4, 30-cycle window)
module tb_trace_capture;

  localparam int XLEN = 32, DEPTH = 4, MAXC = 30;
  localparam int CW = $clog2(MAXC + 1), CNTW = $clog2(DEPTH + 1);

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0, commit = 1'b0, we = 1'b0, ready = 1'b0;
  logic [XLEN-1:0] pc = '0, data = '0;
  logic [31:0]     instr = '0;
  logic [4:0]      rd = '0;
  logic            o_valid, o_we, busy, done, ovf;
  logic [XLEN-1:0] o_pc, o_data;
  logic [31:0]     o_instr;
  logic [4:0]      o_rd;
  logic [CW-1:0]   o_cycle;
  logic [CNTW-1:0] count;

  int tests = 0, fails = 0;

  trace_capture #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .commit_valid_i(commit),
    .pc_i(pc), .instr_i(instr), .rd_we_i(we), .rd_addr_i(rd), .rd_data_i(data),
    .out_valid_o(o_valid), .out_ready_i(ready), .out_pc_o(o_pc), .out_instr_o(o_instr),
    .out_rd_we_o(o_we), .out_rd_addr_o(o_rd), .out_rd_data_o(o_data), .out_cycle_o(o_cycle),
    .count_o(count), .busy_o(busy), .done_o(done), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, data;
    logic        we, exp_we;
    logic [4:0]  rd;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_data"}, {o_pc, o_instr, o_we, o_rd, o_cycle}, 0);
    chk({tag, "_rdata"}, o_data, 0);
  endtask

  task automatic start_window();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    commit = 1'b0;
    ready  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) step();
    chk({tag, "_done_reached"}, done, 1);
    chk({tag, "_empty"}, o_valid, 0);
  endtask

  initial begin
    int rx, first, busy_cnt;
    logic seen_valid;

    vecs[0] = '{pc: 32'h8,  instr: 32'h00500093, data: 32'd5,      we: 1, exp_we: 1, rd: 5'd1};
    vecs[1] = '{pc: 32'h8,  instr: 32'h00500093, data: 32'd5,      we: 1, exp_we: 0, rd: 5'd0};
    vecs[2] = '{pc: 32'hC,  instr: 32'h00A00113, data: 32'd10,     we: 1, exp_we: 1, rd: 5'd2};
    vecs[3] = '{pc: 32'h10, instr: 32'h0020A023, data: 32'h1234,   we: 0, exp_we: 0, rd: 5'd5};

    #2;
    chk_idle_outputs("reset");
    #10 rst = 1'b0;
    step();

    // Exact entry contents and x0 filtering
    start_window();
    chk("start_busy", busy, 1);
    foreach (vecs[i]) begin
      commit = 1'b1; pc = vecs[i].pc; instr = vecs[i].instr;
      we = vecs[i].we; rd = vecs[i].rd; data = vecs[i].data;
      step();
    end
    commit = 1'b0;
    chk("tbl_count", count, 4);
    ready = 1'b1;
    foreach (vecs[i]) begin
      chk("tbl_valid", o_valid, 1);
      chk("tbl_pc", o_pc, vecs[i].pc);
      chk("tbl_instr", o_instr, vecs[i].instr);
      chk("tbl_we", o_we, vecs[i].exp_we);
      chk("tbl_rd", o_rd, vecs[i].rd);
      chk("tbl_data", o_data, vecs[i].data);
      chk("tbl_cycle", o_cycle, i);
      step();
    end
    wait_done("tbl");
    chk("tbl_ovf", ovf, 0);

    // Full window streaming with a commit every cycle
    start_window();
    commit = 1'b1; ready = 1'b1; we = 1'b1; rd = 5'd3; pc = 32'h100;
    rx = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      pc = pc + 4;
      if (o_valid) begin
        chk("stream_cycle", o_cycle, rx);
        chk("stream_pc", o_pc, 32'h100 + 4 * rx);
        rx++;
      end
    end
    chk("stream_entries", rx, 30);
    chk("stream_done", done, 1);
    chk("stream_ovf", ovf, 0);

    // Six commits into a 4-entry buffer with no reads
    start_window();
    ready = 1'b0; commit = 1'b1; pc = 32'h200;
    for (int i = 0; i < 6; i++) begin
      step();
      pc = pc + 4;
    end
    commit = 1'b0;
    chk("ovf_count", count, 4);
    chk("ovf_flag", ovf, 1);
`ifdef TRACE_WRAP_EN
    first = 2;
`else
    first = 0;
`endif
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_cycle", o_cycle, first + k);
      chk("ovf_pc", o_pc, 32'h200 + 4 * (first + k));
      step();
    end
    wait_done("ovf");
    chk("ovf_sticky", ovf, 1);

    // Full buffer with simultaneous read and write
    start_window();
    chk("restart_ovf_clr", ovf, 0);
    ready = 1'b0; commit = 1'b1; pc = 32'h400;
    for (int i = 0; i < 4; i++) begin
      step();
      pc = pc + 4;
    end
    chk("full_count", count, 4);
    chk("full_head", o_cycle, 0);
    ready = 1'b1;
    step();
    chk("rw_count", count, 4);
    chk("rw_ovf", ovf, 0);
    chk("rw_head_cycle", o_cycle, 1);
    chk("rw_head_pc", o_pc, 32'h404);
    wait_done("rw");

    // Asynchronous reset in the middle of a capture window
    start_window();
    commit = 1'b1; ready = 1'b1; pc = 32'h500;
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst_busy", busy, 1);
    #3 rst = 1'b1;
    #1 chk_idle_outputs("async_rst");
    #2 rst = 1'b0;
    commit = 1'b0;
    step();
    start_window();
    commit = 1'b1; ready = 1'b0; pc = 32'h300;
    step();
    commit = 1'b0;
    chk("rst_restart_valid", o_valid, 1);
    chk("rst_restart_cycle", o_cycle, 0);
    chk("rst_restart_pc", o_pc, 32'h300);
    wait_done("rst");

    // Window with no commits: 30 capture cycles plus one drain cycle
    start_window();
    commit = 1'b0; ready = 1'b1;
    busy_cnt = 0; seen_valid = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (busy) busy_cnt++;
      if (o_valid) seen_valid = 1'b1;
      step();
    end
    chk("empty_busy_cycles", busy_cnt, 31);
    chk("empty_no_valid", seen_valid, 0);
    chk("empty_done", done, 1);
    chk("empty_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
